// File: rtl/hazard_control.sv
// hazard_control: ID-stage hazard detection for a 5-stage in-order pipeline.
// Tracks the destination register of the instructions now in EX and MEM,
// stalls IF/ID on load-use and branch-operand hazards, flushes IF/ID on a
// taken branch, and keeps saturating counts of stall and flush cycles.
module hazard_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             Valid_i,
    input  logic [6:0]       Op_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic [4:0]       RDaddr_i,
    input  logic             BranchTaken_i,
    output logic             NoOp_o,
    output logic             Stall_o,
    output logic             PCWrite_o,
    output logic             Flush_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_ST,
        CLS_BR
    } cls_e;

    // Destination of the instruction now in EX.
    typedef struct packed {
        logic       wr;
        logic       ld;
        logic [4:0] rd;
    } ex_shadow_t;

    // Destination of the instruction now in MEM (only loads matter there).
    typedef struct packed {
        logic       ld;
        logic [4:0] rd;
    } mem_shadow_t;

    // True when a live source operand of the IF/ID instruction reads x;
    // x0 is hard-wired to zero and never creates a dependency.
    function automatic logic reg_match(
        input logic [4:0] x,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2
    );
        return (x != 5'd0) && ((use1 && (rs1 == x)) || (use2 && (rs2 == x)));
    endfunction

    cls_e        cls;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        is_br;
    logic        haz_a;
    logic        haz_b;
    logic        haz_c;
    logic        hz;

    ex_shadow_t  ex_q;
    ex_shadow_t  ex_d;
    mem_shadow_t mem_q;
    mem_shadow_t mem_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // Classify the IF/ID instruction and derive which register fields it uses.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path through the block leaves it unassigned (latch).
        cls = CLS_NONE;
        if (Valid_i) begin
            case (Op_i)
                OP_R:    cls = CLS_R;
                OP_I:    cls = CLS_I;
                OP_LD:   cls = CLS_LD;
                OP_ST:   cls = CLS_ST;
                OP_BR:   cls = CLS_BR;
                default: cls = CLS_NONE;
            endcase
        end
        uses_rs1  = (cls != CLS_NONE);
        uses_rs2  = (cls == CLS_R) || (cls == CLS_ST) || (cls == CLS_BR);
        writes_rd = (cls == CLS_R) || (cls == CLS_I) || (cls == CLS_LD);
        is_br     = (cls == CLS_BR);
    end

    // Hazard detection; a stall always wins over a flush so the branch is
    // only resolved once its operands are available.
    always_comb begin
        haz_a = ex_q.ld
                && reg_match(ex_q.rd, RS1addr_i, RS2addr_i, uses_rs1, uses_rs2);
        haz_b = is_br && ex_q.wr
                && reg_match(ex_q.rd, RS1addr_i, RS2addr_i, uses_rs1, uses_rs2);
        haz_c = is_br && mem_q.ld
                && reg_match(mem_q.rd, RS1addr_i, RS2addr_i, uses_rs1, uses_rs2);
        hz        = haz_a || haz_b || haz_c;
        NoOp_o    = hz;
        Stall_o   = hz;
        PCWrite_o = !hz;
        Flush_o   = is_br && BranchTaken_i && !hz;
    end

    // Next-state for the pipeline shadows and the saturating counters.
    always_comb begin
        ex_d = '0;
        if (!hz) begin
            ex_d.wr = writes_rd;
            ex_d.ld = (cls == CLS_LD);
            ex_d.rd = RDaddr_i;
        end

        mem_d.ld = ex_q.ld;
        mem_d.rd = ex_q.rd;

        stall_cnt_d = stall_cnt_q;
        if (hz && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (Flush_o && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt_o = stall_cnt_q;
    assign FlushCnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed, table-driven bench for hazard_control.
// A 16-bit-counter instance carries the main checks; a 4-bit-counter
// instance shares the same stimulus so counter saturation is reachable.
module tb_hazard_control;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_NONE = 7'b1111111;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        taken;
        logic        hz;
        logic        fl;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        taken;

    logic        noop;
    logic        stall;
    logic        pcw;
    logic        flush;
    logic [15:0] scnt;
    logic [15:0] fcnt;

    logic        s_noop;
    logic        s_stall;
    logic        s_pcw;
    logic        s_flush;
    logic [3:0]  s_scnt;
    logic [3:0]  s_fcnt;

    int tests_run;
    int tests_failed;

    vec_t vecs[$];

    hazard_control dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .Valid_i       (valid),
        .Op_i          (op),
        .RS1addr_i     (rs1),
        .RS2addr_i     (rs2),
        .RDaddr_i      (rd),
        .BranchTaken_i (taken),
        .NoOp_o        (noop),
        .Stall_o       (stall),
        .PCWrite_o     (pcw),
        .Flush_o       (flush),
        .StallCnt_o    (scnt),
        .FlushCnt_o    (fcnt)
    );

    hazard_control #(.CNT_W(4)) dut_small (
        .clk_i         (clk),
        .rst_i         (rst),
        .Valid_i       (valid),
        .Op_i          (op),
        .RS1addr_i     (rs1),
        .RS2addr_i     (rs2),
        .RDaddr_i      (rd),
        .BranchTaken_i (taken),
        .NoOp_o        (s_noop),
        .Stall_o       (s_stall),
        .PCWrite_o     (s_pcw),
        .Flush_o       (s_flush),
        .StallCnt_o    (s_scnt),
        .FlushCnt_o    (s_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r, input logic v, input logic [6:0] o,
        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
        input logic t, input logic h, input logic f,
        input logic [15:0] s, input logic [15:0] c
    );
        vec_t x;
        x.rst = r; x.valid = v; x.op = o; x.rs1 = a; x.rs2 = b; x.rd = d;
        x.taken = t; x.hz = h; x.fl = f; x.sc = s; x.fc = c;
        return x;
    endfunction

    // Present one IF/ID instruction at the falling edge; outputs settle by #1.
    task automatic drive(input logic r, input logic v, input logic [6:0] o,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic t);
        @(negedge clk);
        rst = r; valid = v; op = o; rs1 = a; rs2 = b; rd = d; taken = t;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0; taken = 1'b0;

        //        rst valid op       rs1 rs2 rd  tk hz fl sc fc
        vecs.push_back(mk(0, 0, 7'd0,     0,  0,  0, 0, 0, 0, 0, 0)); // r0 reset state
        vecs.push_back(mk(0, 1, OP_LD,    2,  0,  5, 0, 0, 0, 0, 0)); // lw x5
        vecs.push_back(mk(0, 1, OP_R,     5,  1,  6, 0, 1, 0, 0, 0)); // add x6,x5,x1 load-use
        vecs.push_back(mk(0, 1, OP_R,     5,  1,  6, 0, 0, 0, 1, 0)); // add reissued
        vecs.push_back(mk(0, 1, OP_LD,    3,  0,  5, 0, 0, 0, 1, 0)); // lw x5
        vecs.push_back(mk(0, 1, OP_BR,    5,  0,  0, 1, 1, 0, 1, 0)); // beq x5: A+B
        vecs.push_back(mk(0, 1, OP_BR,    5,  0,  0, 1, 1, 0, 2, 0)); // beq x5: C
        vecs.push_back(mk(0, 1, OP_BR,    5,  0,  0, 1, 0, 1, 3, 0)); // beq issues, flush
        vecs.push_back(mk(0, 0, 7'd0,     0,  0,  0, 0, 0, 0, 3, 1)); // bubble
        vecs.push_back(mk(0, 1, OP_LD,    2,  0,  0, 0, 0, 0, 3, 1)); // lw x0
        vecs.push_back(mk(0, 1, OP_R,     0,  0,  6, 0, 0, 0, 3, 1)); // add x6,x0,x0
        vecs.push_back(mk(0, 1, OP_R,     2,  3,  1, 0, 0, 0, 3, 1)); // add x1
        vecs.push_back(mk(0, 1, OP_I,     1,  7,  2, 0, 0, 0, 3, 1)); // addi x2,x1 forwarded
        vecs.push_back(mk(0, 1, OP_LD,    9,  0,  7, 0, 0, 0, 3, 1)); // lw x7
        vecs.push_back(mk(0, 1, OP_I,     9,  7,  8, 0, 0, 0, 3, 1)); // addi ignores rs2 field
        vecs.push_back(mk(0, 1, OP_R,     1,  2,  4, 0, 0, 0, 3, 1)); // add x4
        vecs.push_back(mk(0, 1, OP_BR,    4,  9,  0, 1, 1, 0, 3, 1)); // beq x4: B beats flush
        vecs.push_back(mk(0, 1, OP_BR,    4,  9,  0, 1, 0, 1, 4, 1)); // beq issues, flush
        vecs.push_back(mk(0, 1, OP_BR,    4,  9,  0, 0, 0, 0, 4, 2)); // not-taken beq
        vecs.push_back(mk(0, 1, OP_LD,    0,  0, 11, 0, 0, 0, 4, 2)); // lw x11
        vecs.push_back(mk(0, 1, OP_ST,   12, 11,  0, 0, 1, 0, 4, 2)); // sw x11 via rs2
        vecs.push_back(mk(0, 1, OP_ST,   12, 11,  0, 0, 0, 0, 5, 2)); // sw reissued
        vecs.push_back(mk(0, 1, OP_LD,    0,  0, 13, 0, 0, 0, 5, 2)); // lw x13
        vecs.push_back(mk(0, 1, OP_R,     1,  2, 14, 0, 0, 0, 5, 2)); // independent add
        vecs.push_back(mk(0, 1, OP_BR,    1, 13,  0, 1, 1, 0, 5, 2)); // beq x13: C only
        vecs.push_back(mk(0, 1, OP_BR,    1, 13,  0, 1, 0, 1, 6, 2)); // beq issues, flush
        vecs.push_back(mk(0, 1, OP_LD,    0,  0, 15, 1, 0, 0, 6, 3)); // lw x15, taken ignored
        vecs.push_back(mk(0, 0, OP_BR,   15,  0,  0, 1, 0, 0, 6, 3)); // invalid beq = NONE
        vecs.push_back(mk(0, 1, OP_NONE, 15, 15,  0, 1, 0, 0, 6, 3)); // unknown opcode = NONE
        vecs.push_back(mk(0, 1, OP_LD,    0,  0,  5, 0, 0, 0, 6, 3)); // lw x5
        vecs.push_back(mk(1, 1, OP_BR,    5,  0,  0, 1, 1, 0, 6, 3)); // reset mid-stall
        vecs.push_back(mk(0, 1, OP_BR,    5,  0,  0, 1, 0, 1, 0, 0)); // no stall left
        vecs.push_back(mk(0, 0, 7'd0,     0,  0,  0, 0, 0, 0, 0, 1)); // bubble

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].rd, vecs[i].taken);
            check($sformatf("row%0d NoOp", i),     32'(noop),  32'(vecs[i].hz));
            check($sformatf("row%0d Stall", i),    32'(stall), 32'(vecs[i].hz));
            check($sformatf("row%0d PCWrite", i),  32'(pcw),   32'(!vecs[i].hz));
            check($sformatf("row%0d Flush", i),    32'(flush), 32'(vecs[i].fl));
            check($sformatf("row%0d StallCnt", i), 32'(scnt),  32'(vecs[i].sc));
            check($sformatf("row%0d FlushCnt", i), 32'(fcnt),  32'(vecs[i].fc));
        end

        // Counter saturation: lw x5 / beq x5 / beq x5 gives two stalls per round.
        drive(1, 0, 7'd0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, OP_LD, 0, 0, 5, 0);
            check($sformatf("sat%0d lw stall", i), 32'(stall), 32'd0);
            drive(0, 1, OP_BR, 5, 0, 0, 0);
            check($sformatf("sat%0d beq1 stall", i), 32'(s_stall), 32'd1);
            drive(0, 1, OP_BR, 5, 0, 0, 0);
            check($sformatf("sat%0d beq2 stall", i), 32'(s_stall), 32'd1);
        end
        drive(0, 0, 7'd0, 0, 0, 0, 0);
        check("sat StallCnt16", 32'(scnt),   32'd24);
        check("sat StallCnt4",  32'(s_scnt), 32'd15);
        check("sat FlushCnt4 idle", 32'(s_fcnt), 32'd0);

        // Back-to-back taken branches with no producers: a flush every cycle.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, OP_BR, 0, 0, 0, 1);
            check($sformatf("flushrun%0d Flush", i), 32'(s_flush), 32'd1);
        end
        drive(0, 0, 7'd0, 0, 0, 0, 0);
        check("sat FlushCnt16",   32'(fcnt),   32'd20);
        check("sat FlushCnt4",    32'(s_fcnt), 32'd15);
        check("sat StallCnt4 held", 32'(s_scnt), 32'd15);
        check("sat StallCnt16 held", 32'(scnt), 32'd24);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL: Valid_i  input  1  IF/ID holds a real instruction; 0 = bubble.
REQ-004 SHALL: Op_i  input  7  opcode of IF/ID instruction.
REQ-005 SHALL: RS1addr_i / RS2addr_i / RDaddr_i  input  5 each  register fields of IF/ID instruction.
REQ-006 SHALL: BranchTaken_i  input  1  ID-stage beq compare result.
REQ-007 SHALL: NoOp_o  output  1  forces the decoder to emit all-zero control (bubble into ID/EX).
REQ-008 SHALL: Stall_o  output  1  hold IF/ID register.
REQ-009 SHALL: PCWrite_o  output  1  PC update enable.
REQ-010 SHALL: Flush_o  output  1  zero IF/ID on taken branch.
REQ-011 SHALL: StallCnt_o / FlushCnt_o  output  16 each  saturating event counters.

Function
REQ-012 SHALL: decode classes from Op_i: R=0110011, I=0010011, LD=0000011, ST=0100011, BR=1100011; any other opcode, or Valid_i=0, is class NONE.
REQ-013 SHALL: uses_rs1 = R|I|LD|ST|BR; uses_rs2 = R|ST|BR; writes_rd = R|I|LD; NONE uses/writes nothing.
REQ-014 SHALL: keep EX shadow (ex_wr, ex_ld, ex_rd) and MEM shadow (mem_ld, mem_rd), both registered.
REQ-015 SHALL: each cycle, MEM shadow <= EX shadow, unconditionally.
REQ-016 SHALL: each cycle, EX shadow <= {writes_rd, class==LD, RDaddr_i} of IF/ID instruction when NoOp_o=0, else {0,0,0}.
REQ-017 SHALL: match(x) = x!=0 and ((uses_rs1 and RS1addr_i==x) or (uses_rs2 and RS2addr_i==x)).
REQ-018 SHALL: hazard A (load-use) = ex_ld and match(ex_rd).
REQ-019 SHALL: hazard B (branch after ALU/load) = class BR and ex_wr and match(ex_rd).
REQ-020 SHALL: hazard C (branch two after load) = class BR and mem_ld and match(mem_rd).
REQ-021 SHALL: hz = A|B|C; outputs combinational same cycle: NoOp_o=hz, Stall_o=hz, PCWrite_o=!hz.
REQ-022 SHALL: Flush_o = class BR and BranchTaken_i and !hz; stall takes priority over flush.
REQ-023 SHALL: register x0 never causes a hazard (REQ-017).
REQ-024 SHALL: resulting stall lengths: lw then dependent ALU/ST = 1 cycle; ALU then dependent beq = 1; lw then dependent beq = 2 (A+B, then C); lw, independent, dependent beq = 1 (C).
REQ-025 SHALL: StallCnt_o += 1 each cycle hz=1; FlushCnt_o += 1 each cycle Flush_o=1; both hold at 0xFFFF (no wrap).
REQ-026 SHALL: outputs depend only on current inputs and registered shadows; no combinational path from outputs back to inputs.

Reset
REQ-027 SHALL: while rst_i=1 at a rising edge: EX and MEM shadows cleared to zero, both counters cleared to 0.
REQ-028 SHALL: after reset, NoOp_o=0, Stall_o=0, PCWrite_o=1, Flush_o=0 until a hazard or taken branch is presented.
REQ-029 SHALL: reset asserted mid-stall clears shadows at that edge; next cycle no stall is reported for the pre-reset instruction.

Verification
REQ-030 SHALL: lw x5 then add x6,x5,x1 -> cycle 2: NoOp_o=1, Stall_o=1, PCWrite_o=0; cycle 3: all clear; StallCnt_o=1.
REQ-031 SHALL: lw x5 then beq x5,x0 -> exactly 2 stall cycles, then beq issues; BranchTaken_i=1 at issue -> Flush_o=1 that cycle only; StallCnt_o=2, FlushCnt_o=1.
REQ-032 SHALL: lw x0 then add x6,x0,x0 -> no stall; add x1 then addi x2,x1 -> no stall (forwarded).
REQ-033 SHALL: beq with BranchTaken_i=1 while hazard B active -> Flush_o=0, Stall_o=1; next cycle Flush_o=1.
REQ-034 SHALL: 70000 consecutive forced stalls -> StallCnt_o saturates at 0xFFFF and holds.
REQ-035 SHALL: rst_i=1 during the first stall cycle of lw/beq pair -> after release, no stall cycle attributable to the lw; counters = 0.
